pulse_transmitter_duration_timer: RTL and testbench
===================================================

// Module: pulse_transmitter_duration_timer
// PURPOSE
//  Programmable duration timer for the pulse transmitter. Loads a symbol duration
//  and a prescaler, holds `busy` high for exactly duration*(prescaler+1) clk cycles,
//  then drops it.
//  Sits directly upstream of the falling-edge detector. `busy` feeds its `sig_in`.
//  The detector's 1-cycle pulse on the busy->idle transition is the symbol-done event.
// PARAMETERS
//  COUNTER_WIDTH    8  width of the duration count (symbol units)
//  PRESCALER_WIDTH  4  width of prescaler; one unit = prescaler+1 clk cycles
// PORTS
//  clk          in   1                clock; all logic on posedge
//  rst_n        in   1                reset, synchronous, active-low
//  start        in   1                load request; acted on only in IDLE
//  stop         in   1                abort request; acted on in RUN, wins over start
//  duration     in   COUNTER_WIDTH    duration in units; sampled with start
//  prescaler    in   PRESCALER_WIDTH  divide value; sampled with start
//  busy         out  1                high while timing (registered)
//  unit_tick    out  1                1-cycle pulse at the end of each unit (registered)
//  remaining    out  COUNTER_WIDTH    units left, including the current one (registered)
//  aborted      out  1                high after a stop-terminated run; cleared by next accepted start
// BEHAVIOUR
//  Reset (rst_n=0 at posedge)
//   - state=IDLE; busy=0, unit_tick=0, remaining=0, aborted=0.
//   - Prescale counter and latched prescaler are cleared.
//   - Applies mid-run: busy drops with no extra cycles.
//  States: IDLE, RUN (1-bit state register).
//  IDLE
//   - start=1, stop=0, duration!=0 at edge E:
//     - latch prescaler; remaining<=duration; pcnt<=0; busy<=1; aborted<=0; go to RUN.
//     - busy is visible after E, so latency from start to busy is 1 cycle.
//   - start with duration==0: ignored. Stays IDLE, busy stays 0, no tick.
//   - start and stop together: stop wins, request ignored.
//  RUN, each edge
//   - stop=1: go to IDLE, busy<=0, aborted<=1, unit_tick<=0, remaining<=0.
//   - else if pcnt==latched prescaler: pcnt<=0 and unit_tick<=1.
//     - if remaining==1: remaining<=0, busy<=0, go to IDLE.
//     - else remaining<=remaining-1.
//   - else pcnt<=pcnt+1, unit_tick<=0.
//   - start during RUN is ignored. Inputs are not re-sampled and there is no queueing.
//  Timing
//   - busy is high for exactly duration*(prescaler+1) consecutive cycles.
//   - The last unit_tick is coincident with the first busy=0 cycle.
//   - unit_tick count per completed run equals duration. An aborted run gives fewer or none.
//  Next run
//   - A new start may be accepted on the first cycle busy reads 0.
//   - Back-to-back runs give one busy=0 cycle between them, so the downstream detector sees a falling edge.
//  Arithmetic
//   - remaining never underflows and is only decremented when >=1.
//   - pcnt is PRESCALER_WIDTH bits and never exceeds the latched prescaler.
//   - No wrap-around at maximum values: 255*16 = 4080 cycles.
//  Changes to duration/prescaler inputs during RUN have no effect.
// TESTING
//  1 duration=3, prescaler=0, start 1 cycle
//    -> busy high 3 cycles; unit_tick 3 cycles in a row; remaining 3,2,1,0.
//  2 duration=2, prescaler=3
//    -> busy high 8 cycles; unit_tick on cycles 4 and 8 only; aborted=0.
//  3 duration=0 with start; then start+stop with duration=5 from IDLE
//    -> busy stays 0, no ticks, remaining=0.
//  4 duration=10, prescaler=1, stop after 5 busy cycles
//    -> busy falls next edge; aborted=1; remaining=0; next start clears aborted.
//  5 duration=4, prescaler=0; start pulses in RUN with duration=9
//    -> run still lasts 4 cycles. Re-start on the first idle cycle -> busy gap of exactly 1 cycle.
//  6 duration=255, prescaler=15 -> busy exactly 4080 cycles.
//    Repeat, asserting rst_n=0 at cycle 100 -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pulse_transmitter_duration_timer.sv
`default_nettype none
// ============================================================================
//  Module      : pulse_transmitter_duration_timer
//  Description : Holds busy high for duration*(prescaler+1) cycles, with
//                per-unit tick, remaining-unit count and abort indication.
//  Revision    : 1.0 - initial release
// ============================================================================
module pulse_transmitter_duration_timer #(
    parameter int COUNTER_WIDTH   = 8,
    parameter int PRESCALER_WIDTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic [COUNTER_WIDTH-1:0]   duration,
    input  logic [PRESCALER_WIDTH-1:0] prescaler,
    output logic                       busy,
    output logic                       unit_tick,
    output logic [COUNTER_WIDTH-1:0]   remaining,
    output logic                       aborted
);

    localparam logic [0:0]                 c_IDLE      = 1'b0;
    localparam logic [0:0]                 c_RUN       = 1'b1;
    localparam logic [COUNTER_WIDTH-1:0]   c_REM_ZERO  = '0;
    localparam logic [COUNTER_WIDTH-1:0]   c_REM_ONE   = COUNTER_WIDTH'(1);
    localparam logic [PRESCALER_WIDTH-1:0] c_PCNT_ZERO = '0;
    localparam logic [PRESCALER_WIDTH-1:0] c_PCNT_ONE  = PRESCALER_WIDTH'(1);

    logic [0:0]                 r_state;
    logic [0:0]                 w_state_next;
    logic [PRESCALER_WIDTH-1:0] r_pcnt;
    logic [PRESCALER_WIDTH-1:0] r_presc;
    logic [COUNTER_WIDTH-1:0]   r_remaining;
    logic                       r_busy;
    logic                       r_unit_tick;
    logic                       r_aborted;

    logic [PRESCALER_WIDTH-1:0] w_pcnt_next;
    logic [PRESCALER_WIDTH-1:0] w_presc_next;
    logic [COUNTER_WIDTH-1:0]   w_remaining_next;
    logic                       w_busy_next;
    logic                       w_unit_tick_next;
    logic                       w_aborted_next;

    logic w_accept;
    logic w_unit_end;
    logic w_last_unit;

    // stop beats start in IDLE; a zero duration is never a valid run
    assign w_accept    = (r_state == c_IDLE) && start && !stop && (duration != c_REM_ZERO);
    assign w_unit_end  = (r_state == c_RUN) && !stop && (r_pcnt == r_presc);
    assign w_last_unit = w_unit_end && (r_remaining == c_REM_ONE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_pcnt      <= c_PCNT_ZERO;
            r_presc     <= c_PCNT_ZERO;
            r_remaining <= c_REM_ZERO;
            r_busy      <= 1'b0;
            r_unit_tick <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_pcnt      <= w_pcnt_next;
            r_presc     <= w_presc_next;
            r_remaining <= w_remaining_next;
            r_busy      <= w_busy_next;
            r_unit_tick <= w_unit_tick_next;
            r_aborted   <= w_aborted_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (w_accept) w_state_next = c_RUN;
            c_RUN:   if (stop || w_last_unit) w_state_next = c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_comb begin
        w_pcnt_next      = r_pcnt;
        w_presc_next     = r_presc;
        w_remaining_next = r_remaining;
        w_busy_next      = r_busy;
        w_unit_tick_next = 1'b0;
        w_aborted_next   = r_aborted;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_presc_next     = prescaler;
                    w_remaining_next = duration;
                    w_pcnt_next      = c_PCNT_ZERO;
                    w_busy_next      = 1'b1;
                    w_aborted_next   = 1'b0;
                end
            end
            c_RUN: begin
                if (stop) begin
                    w_busy_next      = 1'b0;
                    w_aborted_next   = 1'b1;
                    w_remaining_next = c_REM_ZERO;
                end else if (w_unit_end) begin
                    w_pcnt_next      = c_PCNT_ZERO;
                    w_unit_tick_next = 1'b1;
                    if (w_last_unit) begin
                        w_remaining_next = c_REM_ZERO;
                        w_busy_next      = 1'b0;
                    end else begin
                        w_remaining_next = r_remaining - c_REM_ONE;
                    end
                end else begin
                    w_pcnt_next = r_pcnt + c_PCNT_ONE;
                end
            end
            default: begin
                w_busy_next = 1'b0;
            end
        endcase
    end

    assign busy      = r_busy;
    assign unit_tick = r_unit_tick;
    assign remaining = r_remaining;
    assign aborted   = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_pulse_transmitter_duration_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pulse_transmitter_duration_timer
//  Description : Directed and random stimulus against an elapsed-time model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pulse_transmitter_duration_timer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [7:0] duration = '0;
    logic [3:0] prescaler = '0;
    logic       busy;
    logic       unit_tick;
    logic [7:0] remaining;
    logic       aborted;

    int n_total = 0;
    int n_bad   = 0;

    // reference: cycles elapsed since acceptance, units derived by division
    bit m_active  = 1'b0;
    bit m_tick    = 1'b0;
    bit m_aborted = 1'b0;
    int m_t       = 0;
    int m_d       = 0;
    int m_p       = 0;
    int m_rem     = 0;

    pulse_transmitter_duration_timer #(
        .COUNTER_WIDTH   (8),
        .PRESCALER_WIDTH (4)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .stop      (stop),
        .duration  (duration),
        .prescaler (prescaler),
        .busy      (busy),
        .unit_tick (unit_tick),
        .remaining (remaining),
        .aborted   (aborted)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_active  <= 1'b0;
            m_tick    <= 1'b0;
            m_rem     <= 0;
            m_aborted <= 1'b0;
        end else if (m_active) begin
            if (stop) begin
                m_active  <= 1'b0;
                m_aborted <= 1'b1;
                m_tick    <= 1'b0;
                m_rem     <= 0;
            end else begin
                m_t    <= m_t + 1;
                m_tick <= ((m_t + 1) % (m_p + 1)) == 0;
                m_rem  <= m_d - (m_t + 1) / (m_p + 1);
                if (m_t + 1 == m_d * (m_p + 1)) m_active <= 1'b0;
            end
        end else begin
            m_tick <= 1'b0;
            if (start && !stop && duration != 8'd0) begin
                m_active  <= 1'b1;
                m_t       <= 0;
                m_d       <= int'(duration);
                m_p       <= int'(prescaler);
                m_aborted <= 1'b0;
                m_rem     <= int'(duration);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    // wait for a negedge, compare outputs to the model, then apply next inputs
    task automatic drive(input logic r, input logic s, input logic p,
                         input logic [7:0] d, input logic [3:0] ps);
        @(negedge clk);
        check("busy",      32'(busy),      32'(m_active));
        check("unit_tick", 32'(unit_tick), 32'(m_tick));
        check("remaining", 32'(remaining), 32'(m_rem));
        check("aborted",   32'(aborted),   32'(m_aborted));
        rst_n     = r;
        start     = s;
        stop      = p;
        duration  = d;
        prescaler = ps;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt;
        int tick_cnt;

        drive(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_rem",  32'(remaining), 32'd0);
        idle_cycles(2);

        // three one-cycle units back to back
        drive(1'b1, 1'b1, 1'b0, 8'd3, 4'd0);
        busy_cnt = 0; tick_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
            busy_cnt += int'(busy);
            tick_cnt += int'(unit_tick);
        end
        check("t1_busy_len", 32'(busy_cnt), 32'd3);
        check("t1_ticks",    32'(tick_cnt), 32'd3);

        drive(1'b1, 1'b1, 1'b0, 8'd2, 4'd3);
        busy_cnt = 0; tick_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
            busy_cnt += int'(busy);
            tick_cnt += int'(unit_tick);
        end
        check("t2_busy_len", 32'(busy_cnt), 32'd8);
        check("t2_ticks",    32'(tick_cnt), 32'd2);

        // zero duration, then start with stop
        drive(1'b1, 1'b1, 1'b0, 8'd0, 4'd2);
        drive(1'b1, 1'b1, 1'b1, 8'd5, 4'd0);
        idle_cycles(3);
        check("t3_busy", 32'(busy), 32'd0);

        // abort after five busy cycles, then restart clears aborted
        drive(1'b1, 1'b1, 1'b0, 8'd10, 4'd1);
        idle_cycles(5);
        drive(1'b1, 1'b0, 1'b1, 8'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        check("t4_aborted", 32'(aborted), 32'd1);
        check("t4_busy",    32'(busy), 32'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd1, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        check("t4_abort_clr", 32'(aborted), 32'd0);
        idle_cycles(3);

        // starts during run ignored; immediate restart leaves a 1-cycle gap
        drive(1'b1, 1'b1, 1'b0, 8'd4, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd9, 4'd7);
        drive(1'b1, 1'b1, 1'b0, 8'd9, 4'd7);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        drive(1'b1, 1'b1, 1'b0, 8'd2, 4'd0);
        check("t5_gap_idle", 32'(busy), 32'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        check("t5_restart", 32'(busy), 32'd1);
        idle_cycles(4);

        // maximum run
        drive(1'b1, 1'b1, 1'b0, 8'd255, 4'd15);
        busy_cnt = 0;
        for (int i = 0; i < 4200; i++) begin
            drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
            busy_cnt += int'(busy);
        end
        check("t6_busy_len", 32'(busy_cnt), 32'd4080);

        // reset mid-run
        drive(1'b1, 1'b1, 1'b0, 8'd255, 4'd15);
        idle_cycles(100);
        drive(1'b0, 1'b0, 1'b0, 8'd0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 8'd0, 4'd0);
        check("t6_rst_busy", 32'(busy), 32'd0);
        check("t6_rst_rem",  32'(remaining), 32'd0);
        idle_cycles(2);

        for (int i = 0; i < 6000; i++) begin
            drive(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 12)),
                  ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3)));
        end
        idle_cycles(2);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
